// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-decoded empty/full flags and registered read data
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   wr_en      write request, accepted when not full or when paired with a read
//   wr_data    word stored on an accepted write
//   rd_en      read request, accepted when not empty
//   rd_data    registered read data, updated one cycle after an accepted read
//   fifo_empty high when count = 0
//   fifo_full  high when count = DEPTH
//   count      occupancy 0..DEPTH
// Optional: define SYNC_FIFO_ASSERT_EN to compile overflow/underflow/count immediate assertions.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_acc, rd_acc;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == (ADDR_W+1)'(DEPTH);
  assign count      = count_q;
  assign rd_data    = rd_data_q;
  // A paired read frees the slot the write lands in, so a full FIFO still accepts the write.
  assign wr_acc = wr_en & (~fifo_full | rd_en);
  assign rd_acc = rd_en & ~fifo_empty;
  always_comb begin
    wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    rd_data_d = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    count_d   = (wr_acc & ~rd_acc) ? count_q + (ADDR_W+1)'(1) :
                (rd_acc & ~wr_acc) ? count_q - (ADDR_W+1)'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Storage is deliberately unreset; reads only ever reach written entries.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end
`ifdef SYNC_FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(wr_en && fifo_full && !rd_en)) else $error("overflow");
      assert (!(rd_en && fifo_empty)) else $error("underflow");
      assert (count_q <= (ADDR_W+1)'(DEPTH)) else $error("count out of range");
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench comparing sync_fifo against a queue-based reference model
module tb_sync_fifo;
  localparam int DW = 8;
  localparam int D = 8;
  typedef struct packed {
    logic [DW-1:0] rd;
    logic [3:0]    cnt;
  } exp_t;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          wr_en = 0;
  logic          rd_en = 0;
  logic [DW-1:0] wr_data = 0;
  logic [DW-1:0] rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    count;
  exp_t          sb[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] last_rd = 0;
  int            checks = 0;
  int            errors = 0;
  sync_fifo #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // One bus cycle: drive at negedge, advance the model by the FIFO rules, queue the expected outcome.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic ra, wa;
    exp_t e;
    @(negedge clk);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    ra = r && mq.size() > 0;
    wa = w && (mq.size() < D || r);
    if (ra) last_rd = mq.pop_front();
    if (wa) mq.push_back(d);
    e.rd = last_rd;
    e.cnt = 4'(mq.size());
    sb.push_back(e);
  endtask
  task automatic reset_check();
    @(negedge clk);
    wr_en = 0;
    rd_en = 0;
    rst_n = 0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    mq.delete();
    last_rd = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", 32'(rd_data), 32'(e.rd));
      chk("count", 32'(count), 32'(e.cnt));
      chk("empty", 32'(fifo_empty), 32'(e.cnt == 0));
      chk("full", 32'(fifo_full), 32'(e.cnt == D));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("init_count", 32'(count), 0);
    chk("init_empty", 32'(fifo_empty), 1);
    chk("init_full", 32'(fifo_full), 0);
    chk("init_rd_data", 32'(rd_data), 0);
    rst_n = 1;
    for (int i = 0; i < D; i++) step(1, 8'h10 + 8'(i), 0);
    step(1, 8'hAA, 0);
    for (int i = 0; i < D; i++) step(0, 0, 1);
    step(0, 0, 1);
    step(1, 8'h55, 1);
    for (int i = 0; i < D - 1; i++) step(1, 8'(i * 3 + 1), 0);
    step(1, 8'h99, 1);
    for (int i = 0; i < D; i++) step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'h60 + i), 0);
      step(0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0);
    step(0, 0, 0);
    reset_check();
    step(0, 0, 1);
    for (int i = 0; i < 400; i++) step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 1 : $urandom));
    for (int i = 0; i < D + 1; i++) step(0, 0, 1);
    step(0, 0, 0);
    @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
